// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: queues one-hot source / destination-mask requests
// and issues one registered bus transfer per cycle, with stall and sticky source error.
module bus_xfer_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [23:0]   req_src,
  input  logic [23:0]   req_dst,
  input  logic          stall,
  output logic [4:0]    bus_select,
  output logic [23:0]   dst_enable,
  output logic          xfer_active,
  output logic          err_src,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  sel;
    logic [23:0] dst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      sel_q, sel_d;
  logic [23:0]     dst_q, dst_d;
  logic            xfer_q, xfer_d;
  logic            err_q, err_d;

  logic [4:0]      src_sel;
  logic            src_legal;
  logic            accept;
  logic            push;
  logic            pop;

  // Ready looks only at the registered count, never at this edge's pop.
  assign req_ready = clear && (count_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign src_legal = $onehot(req_src);
  assign push      = accept && src_legal;
  assign pop       = !stall && (count_q != '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    src_sel = '0;
    for (int i = 0; i < 24; i++) begin
      if (req_src[i]) src_sel = 5'(i);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    sel_d    = sel_q;
    dst_d    = dst_q;
    xfer_d   = xfer_q;
    err_d    = err_q | (accept & ~src_legal);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    // A stalled stage holds everything, including asserted enables.
    if (!stall) begin
      if (count_q != '0) begin
        sel_d    = mem_q[rd_ptr_q].sel;
        dst_d    = mem_q[rd_ptr_q].dst;
        xfer_d   = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        dst_d  = '0;
        xfer_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= '0;
      dst_q    <= '0;
      xfer_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      dst_q    <= dst_d;
      xfer_q   <= xfer_d;
      err_q    <= err_d;
    end
  end

  // NOTE: queue storage is not reset; zeroed pointers and count make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: src_sel, dst: req_dst};
  end

  assign bus_select  = sel_q;
  assign dst_enable  = dst_q;
  assign xfer_active = xfer_q;
  assign err_src     = err_q;
  assign count       = count_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_bus_xfer_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic [23:0]   req_src;
  logic [23:0]   req_dst;
  logic          stall;
  logic [4:0]    bus_select;
  logic [23:0]   dst_enable;
  logic          xfer_active;
  logic          err_src;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  bus_xfer_sequencer #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .stall      (stall),
    .bus_select (bus_select),
    .dst_enable (dst_enable),
    .xfer_active(xfer_active),
    .err_src    (err_src),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  sel;
    logic [23:0] dst;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_head;
  logic [4:0]  m_sel  = '0;
  logic [23:0] m_dst  = '0;
  logic        m_xfer = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_acc;

  function automatic logic [4:0] hot_index(input logic [23:0] s);
    for (int i = 0; i < 24; i++) if (s[i]) return 5'(i);
    return 5'd0;
  endfunction

  always @(negedge clear) begin
    mq.delete();
    m_sel  = '0;
    m_dst  = '0;
    m_xfer = 1'b0;
    m_err  = 1'b0;
  end

  always @(posedge clock) begin
    if (clear === 1'b1) begin
      m_acc = req_valid && (mq.size() < DEPTH);
      if (!stall) begin
        if (mq.size() > 0) begin
          m_head = mq.pop_front();
          m_sel  = m_head.sel;
          m_dst  = m_head.dst;
          m_xfer = 1'b1;
        end else begin
          m_xfer = 1'b0;
          m_dst  = '0;
        end
      end
      if (m_acc) begin
        if ($countones(req_src) == 1) mq.push_back('{sel: hot_index(req_src), dst: req_dst});
        else m_err = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    check("req_ready",   32'(req_ready),   32'((clear === 1'b1) && (mq.size() < DEPTH)));
    check("count",       32'(count),       32'(mq.size()));
    check("bus_select",  32'(bus_select),  32'(m_sel));
    check("dst_enable",  32'(dst_enable),  32'(m_dst));
    check("xfer_active", 32'(xfer_active), 32'(m_xfer));
    check("err_src",     32'(err_src),     32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [23:0] s, input logic [23:0] d);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    cyc();
    req_valid = 1'b0;
  endtask

  logic [23:0] frozen_dst;

  initial begin
    clear     = 1'b0;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    stall     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_xfer",  32'(xfer_active), 32'd0);
    check("rst_sel",   32'(bus_select), 32'd0);
    check("rst_err",   32'(err_src), 32'd0);
    #1 clear = 1'b1;

    // Single transfer: PC -> R3
    push(24'h1 << 20, 24'h000008);
    check("t1_count_e1", 32'(count), 32'd1);
    check("t1_xfer_e1",  32'(xfer_active), 32'd0);
    cyc();
    check("t1_sel_e2",  32'(bus_select), 32'd20);
    check("t1_dst_e2",  32'(dst_enable), 32'h8);
    check("t1_xfer_e2", 32'(xfer_active), 32'd1);
    cyc();
    check("t1_xfer_e3", 32'(xfer_active), 32'd0);
    check("t1_sel_e3",  32'(bus_select), 32'd20);
    check("t1_dst_e3",  32'(dst_enable), 32'h0);

    // Fill and drain
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(24'h1 << i, 24'h1 << (i + 8));
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready", 32'(req_ready), 32'd0);
    push(24'h1 << 5, 24'h1);
    check("fill_reject", 32'(count), 32'd4);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("drain_sel",   32'(bus_select), 32'(i));
      check("drain_count", 32'(count), 32'(4 - i));
      check("drain_dst",   32'(dst_enable), 32'h1 << (i + 8));
    end
    cyc();
    check("drain_idle", 32'(xfer_active), 32'd0);

    // Illegal sources
    check("ill_ready0", 32'(req_ready), 32'd1);
    push(24'h000003, 24'h1);
    check("ill_ready1", 32'(req_ready), 32'd1);
    push(24'h000000, 24'h1);
    check("ill_count", 32'(count), 32'd0);
    check("ill_err",   32'(err_src), 32'd1);
    repeat (3) cyc();
    check("ill_sticky", 32'(err_src), 32'd1);
    check("ill_noxfer", 32'(xfer_active), 32'd0);

    // Stall mid-stream
    stall = 1'b1;
    for (int i = 5; i <= 7; i++) push(24'h1 << i, 24'h1 << i);
    stall = 1'b0;
    cyc();
    check("st_sel0", 32'(bus_select), 32'd5);
    frozen_dst = dst_enable;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("st_frz_sel",   32'(bus_select), 32'd5);
      check("st_frz_dst",   32'(dst_enable), 32'(frozen_dst));
      check("st_frz_xfer",  32'(xfer_active), 32'd1);
      check("st_frz_count", 32'(count), 32'd2);
    end
    stall = 1'b0;
    cyc();
    check("st_sel1", 32'(bus_select), 32'd6);
    cyc();
    check("st_sel2", 32'(bus_select), 32'd7);
    cyc();

    // Simultaneous push and pop at count 2
    stall = 1'b1;
    push(24'h1 << 8, 24'h0);
    push(24'h1 << 9, 24'h0);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        req_valid = 1'b1;
        req_src   = 24'h1 << (10 + i);
        req_dst   = '0;
      end else begin
        req_valid = 1'b0;
      end
      cyc();
      check("pp_sel",  32'(bus_select), 32'(8 + i));
      check("pp_xfer", 32'(xfer_active), 32'd1);
      check("pp_dst0", 32'(dst_enable), 32'd0);
      if (i < 3) check("pp_count", 32'(count), 32'd2);
    end
    req_valid = 1'b0;
    cyc();

    // Asynchronous reset mid-operation
    stall = 1'b1;
    for (int i = 13; i <= 16; i++) push(24'h1 << i, 24'hFFFFFF);
    stall = 1'b0;
    cyc();
    check("mr_xfer_pre",  32'(xfer_active), 32'd1);
    check("mr_count_pre", 32'(count), 32'd3);
    #1 clear = 1'b0;
    #1;
    check("mr_dst",   32'(dst_enable), 32'd0);
    check("mr_xfer",  32'(xfer_active), 32'd0);
    check("mr_count", 32'(count), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    check("mr_err",   32'(err_src), 32'd0);
    cyc();
    clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("mr_nothing", 32'(xfer_active), 32'd0);
    end

    // Randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      req_valid = ($urandom_range(0, 9) < 6);
      if (r == 0)      req_src = '0;
      else if (r == 1) req_src = (24'h1 << $urandom_range(0, 11)) | (24'h1 << $urandom_range(12, 23));
      else             req_src = 24'h1 << $urandom_range(0, 23);
      req_dst = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom());
      stall   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        clear = 1'b0;
        #1;
        check("rnd_rst_count", 32'(count), 32'd0);
        check("rnd_rst_xfer",  32'(xfer_active), 32'd0);
        cyc();
        cyc();
        clear = 1'b1;
      end else begin
        cyc();
      end
    end

    req_valid = 1'b0;
    stall     = 1'b0;
    repeat (DEPTH + 2) cyc();
    check("final_empty", 32'(count), 32'd0);
    check("final_idle",  32'(xfer_active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
